// File: rtl/gs_div_seq.sv
// Iterative Goldschmidt divider for the 8-bit float format (s, e[3:0] bias 7, f[2:0]).
// One refinement step per clock; valid/ready on both the operand and the result side.
module gs_div_seq #(
    parameter int ITER = 3,
    parameter int MW   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] Q,
    output logic       dz,
    output logic       ovf,
    output logic       unf,
    output logic [2:0] iters
);

    localparam int FB = MW - 2;   // fraction bits of the Q2.x mantissa

    typedef enum logic [1:0] {ST_IDLE, ST_SEED, ST_ITER, ST_DONE} state_t;

    state_t            state;
    logic [7:0]        a_r, b_r;
    logic [MW-1:0]     n, d, f;
    logic [2:0]        cnt;
    logic signed [5:0] e;
    logic              s;

    logic [2*MW-1:0]   pn, pd;
    logic [MW-1:0]     n_nx, d_nx, f_nx;
    logic [MW:0]       f_full;
    logic signed [5:0] exp_p;
    logic [2:0]        frac_p;
    logic              last_step;

    // Reciprocal seed round(2^FB / 1.bbb), tabulated for the Q2.8 mantissa.
    function automatic logic [MW-1:0] seed(input logic [2:0] frac);
        case (frac)
            3'd0:    seed = MW'(256);
            3'd1:    seed = MW'(228);
            3'd2:    seed = MW'(205);
            3'd3:    seed = MW'(186);
            3'd4:    seed = MW'(171);
            3'd5:    seed = MW'(158);
            3'd6:    seed = MW'(146);
            default: seed = MW'(137);
        endcase
    endfunction

    function automatic logic [MW-1:0] mant(input logic [2:0] frac);
        mant = {2'b01, frac, {(FB - 3){1'b0}}};
    endfunction

    // NOTE: every signal of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        pn        = (2*MW)'(n) * (2*MW)'(f);
        pd        = (2*MW)'(d) * (2*MW)'(f);
        n_nx      = (pn[2*MW-1:2*MW-2] != 2'b00) ? '1 : pn[2*MW-3:FB];
        d_nx      = (pd[2*MW-1:2*MW-2] != 2'b00) ? '1 : pd[2*MW-3:FB];
        f_full    = (MW+1)'(1 << (MW - 1)) - (MW+1)'(d_nx);
        f_nx      = f_full[MW-1:0];
        last_step = (cnt + 3'd1 == 3'(ITER)) || (d_nx == MW'(1 << FB));
        // A quotient mantissa below 1.0 is renormalised by one bit.
        exp_p     = n[FB] ? e : e - 6'sd1;
        frac_p    = n[FB] ? n[FB-1:FB-3] : n[FB-2:FB-4];
    end

    // NOTE: all state, datapath and output registers take the async reset, so an abandoned division leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Q         <= 8'h00;
            dz        <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            iters     <= 3'd0;
            a_r       <= 8'h00;
            b_r       <= 8'h00;
            n         <= '0;
            d         <= '0;
            f         <= '0;
            cnt       <= 3'd0;
            e         <= 6'sd0;
            s         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r      <= A;
                        b_r      <= B;
                        in_ready <= 1'b0;
                        dz       <= 1'b0;
                        ovf      <= 1'b0;
                        unf      <= 1'b0;
                        state    <= (B == 8'h00 || A == 8'h00) ? ST_DONE : ST_SEED;
                    end
                end
                ST_SEED: begin
                    n     <= mant(a_r[2:0]);
                    d     <= mant(b_r[2:0]);
                    f     <= seed(b_r[2:0]);
                    cnt   <= 3'd0;
                    e     <= $signed({2'b00, a_r[6:3]}) - $signed({2'b00, b_r[6:3]}) + 6'sd7;
                    s     <= a_r[7] ^ b_r[7];
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    n   <= n_nx;
                    d   <= d_nx;
                    f   <= f_nx;
                    cnt <= cnt + 3'd1;
                    if (last_step) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!out_valid) begin
                        // First DONE cycle packs the result; later cycles only hold it.
                        out_valid <= 1'b1;
                        if (b_r == 8'h00) begin
                            Q     <= {a_r[7], 7'h7F};
                            dz    <= 1'b1;
                            iters <= 3'd0;
                        end else if (a_r == 8'h00) begin
                            Q     <= 8'h00;
                            iters <= 3'd0;
                        end else begin
                            iters <= cnt;
                            if (exp_p > 6'sd15) begin
                                Q   <= {s, 7'h7F};
                                ovf <= 1'b1;
                            end else if (exp_p[5]) begin
                                Q   <= 8'h00;
                                unf <= 1'b1;
                            end else begin
                                Q <= {s, exp_p[3:0], frac_p};
                            end
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gs_div_seq.sv
// Directed and random bench for gs_div_seq: a behavioural model fills a scoreboard on drive,
// results are popped and compared (value, flags, iteration count, latency) when out_valid rises.
module tb_gs_div_seq;

    localparam int ITER = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A, B;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Q;
    logic       dz, ovf, unf;
    logic [2:0] iters;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] q;
        logic       dz;
        logic       ovf;
        logic       unf;
        logic [2:0] iters;
        logic [7:0] lat;
    } exp_t;

    exp_t sb[$];

    localparam logic [9:0] SEED_TAB [8] = '{10'd256, 10'd228, 10'd205, 10'd186,
                                            10'd171, 10'd158, 10'd146, 10'd137};

    gs_div_seq #(.ITER(ITER), .MW(10)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready),
        .Q(Q), .dz(dz), .ovf(ovf), .unf(unf), .iters(iters)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference divider written straight from the number format and truncation rules.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t        r;
        logic [9:0]  n, d, f;
        logic [19:0] pn, pd;
        logic [2:0]  frac;
        int          k, ex;
        r = '0;
        if (b == 8'h00) begin
            r.q = {a[7], 7'h7F}; r.dz = 1'b1; r.lat = 8'd1;
            return r;
        end
        if (a == 8'h00) begin
            r.lat = 8'd1;
            return r;
        end
        n = {2'b01, a[2:0], 5'b00000};
        d = {2'b01, b[2:0], 5'b00000};
        f = SEED_TAB[b[2:0]];
        k = 0;
        do begin
            pn = 20'(n) * 20'(f);
            pd = 20'(d) * 20'(f);
            n  = (pn >= 20'h40000) ? 10'h3FF : pn[17:8];
            d  = (pd >= 20'h40000) ? 10'h3FF : pd[17:8];
            f  = 10'(1024 + 512 - int'(d));
            k++;
        end while (k < ITER && d != 10'd256);
        ex   = int'(a[6:3]) - int'(b[6:3]) + 7;
        frac = n[8] ? n[7:5] : n[6:4];
        if (!n[8]) ex--;
        if (ex > 15) begin
            r.q = {a[7] ^ b[7], 7'h7F}; r.ovf = 1'b1;
        end else if (ex < 0) begin
            r.q = 8'h00; r.unf = 1'b1;
        end else begin
            r.q = {a[7] ^ b[7], ex[3:0], frac};
        end
        r.iters = 3'(k);
        r.lat   = 8'(2 + k);
        return r;
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold);
        exp_t exp;
        int   cycles;
        sb.push_back(model(a, b));
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        A = a; B = b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(posedge clk);
            #1 cycles++;
        end
        exp = sb.pop_front();
        if (!out_valid) begin
            check("timeout", out_valid, 1);
            return;
        end
        check($sformatf("q_%h_%h", a, b), Q, exp.q);
        check("dz", dz, exp.dz);
        check("ovf", ovf, exp.ovf);
        check("unf", unf, exp.unf);
        check("iters", iters, exp.iters);
        check("latency", cycles, exp.lat);
        check("in_ready_busy", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_q", Q, exp.q);
            check("hold_flags", {dz, ovf, unf, iters}, {exp.dz, exp.ovf, exp.unf, exp.iters});
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("valid_dropped", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = 8'h00; B = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_q", Q, 8'h00);
        check("rst_flags", {dz, ovf, unf, iters}, 6'd0);
        rst = 1'b0;

        run_op(8'h38, 8'h38, 0);   // 1.0 / 1.0
        run_op(8'h44, 8'h3C, 0);   // 3.0 / 1.5
        run_op(8'hB8, 8'h40, 0);   // -1.0 / 2.0
        run_op(8'h7F, 8'h08, 0);   // exponent overflow
        run_op(8'h7F, 8'h38, 0);   // exponent exactly 15
        run_op(8'h08, 8'h78, 0);   // exponent underflow
        run_op(8'h38, 8'h00, 0);   // divide by zero
        run_op(8'hB8, 8'h00, 0);   // divide by zero, negative dividend
        run_op(8'h00, 8'h40, 0);   // zero dividend
        run_op(8'h00, 8'h00, 0);   // 0/0 reports dz
        run_op(8'h38, 8'h3D, 0);   // 1.625: truncation lands on D=256 after one step
        run_op(8'h40, 8'h3B, 0);   // 1.375: D sticks at 255, uses all iterations
        run_op(8'h44, 8'h3C, 5);   // backpressure

        // Reset while iterating: outputs return to reset values and no result appears.
        @(negedge clk);
        A = 8'h40; B = 8'h3B; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_q", Q, 8'h00);
        check("midrst_flags", {dz, ovf, unf, iters}, 6'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 check("midrst_no_valid", out_valid, 0);
        end

        run_op(8'h40, 8'h3B, 0);
        for (int i = 0; i < 12; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), i % 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
